data_path: RTL and testbench

//  Single-cycle RV32I integer datapath (no instruction memory). Instruction word is driven

---
 rtl/data_path.sv | 188 ++++++++++++++++++
 tb/tb_data_path.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_path.sv
`timescale 1ns/1ps
// Single-cycle RV32I integer datapath: PC, 32x32 register file, immediate
// generator, ALU and branch resolution. The instruction word is supplied externally each cycle.
module data_path #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_word,
    output logic [31:0] Addition_result,
    output logic        RF_WRITING,
    output logic [31:0] Alu_Result
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned RIDX = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] regs [NREG];

    logic [6:0]      opcode;
    logic [RIDX-1:0] rd;
    logic [RIDX-1:0] rs1;
    logic [RIDX-1:0] rs2;
    logic [2:0]      funct3;
    logic            alt_bit;

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] pc_plus4;

    logic [XLEN-1:0] alu_c;
    logic            rf_we_c;
    logic [XLEN-1:0] next_pc_c;
    logic            br_taken_c;

    // Instruction field extraction and immediate formats
    assign opcode  = instruction_word[6:0];
    assign rd      = instruction_word[11:7];
    assign funct3  = instruction_word[14:12];
    assign rs1     = instruction_word[19:15];
    assign rs2     = instruction_word[24:20];
    assign alt_bit = instruction_word[30];

    assign imm_i = {{20{instruction_word[31]}}, instruction_word[31:20]};
    assign imm_u = {instruction_word[31:12], 12'b0};
    assign imm_b = {{20{instruction_word[31]}}, instruction_word[7],
                    instruction_word[30:25], instruction_word[11:8], 1'b0};
    assign imm_j = {{12{instruction_word[31]}}, instruction_word[19:12],
                    instruction_word[20], instruction_word[30:21], 1'b0};

    // x0 is never written, so a plain array read already returns zero for it
    assign rs1_val  = regs[rs1];
    assign rs2_val  = regs[rs2];
    assign pc_plus4 = pc + XLEN'(4);

    function automatic logic [XLEN-1:0] alu_op(
        input logic [2:0]      f3,
        input logic            alt,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [XLEN-1:0] res;
        res = '0;
        case (f3)
            F3_ADD:  res = alt ? (a - b) : (a + b);
            F3_SLL:  res = a << b[4:0];
            F3_SLT:  res = XLEN'($signed(a) < $signed(b));
            F3_SLTU: res = XLEN'(a < b);
            F3_XOR:  res = a ^ b;
            F3_SR:   res = alt ? XLEN'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            F3_OR:   res = a | b;
            F3_AND:  res = a & b;
            default: res = '0;
        endcase
        return res;
    endfunction

    // Branch condition resolution
    always_comb begin
        br_taken_c = 1'b0;
        case (funct3)
            F3_BEQ:  br_taken_c = (rs1_val == rs2_val);
            F3_BNE:  br_taken_c = (rs1_val != rs2_val);
            F3_BLT:  br_taken_c = ($signed(rs1_val) <  $signed(rs2_val));
            F3_BGE:  br_taken_c = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: br_taken_c = (rs1_val <  rs2_val);
            F3_BGEU: br_taken_c = (rs1_val >= rs2_val);
            default: br_taken_c = 1'b0;
        endcase
    end

    // Decode: result value, write strobe and next PC per opcode
    always_comb begin
        alu_c     = rs1_val + rs2_val;
        rf_we_c   = 1'b0;
        next_pc_c = pc_plus4;
        case (opcode)
            OPC_OP: begin
                alu_c   = alu_op(funct3, alt_bit, rs1_val, rs2_val);
                rf_we_c = 1'b1;
            end
            OPC_OP_IMM: begin
                // ADDI has no subtract form; only SRAI uses imm[10]
                alu_c   = alu_op(funct3, (funct3 == F3_SR) && alt_bit, rs1_val, imm_i);
                rf_we_c = 1'b1;
            end
            OPC_LUI: begin
                alu_c   = imm_u;
                rf_we_c = 1'b1;
            end
            OPC_AUIPC: begin
                alu_c   = pc + imm_u;
                rf_we_c = 1'b1;
            end
            OPC_JAL: begin
                alu_c     = pc_plus4;
                rf_we_c   = 1'b1;
                next_pc_c = pc + imm_j;
            end
            OPC_JALR: begin
                alu_c     = pc_plus4;
                rf_we_c   = 1'b1;
                next_pc_c = (rs1_val + imm_i) & ~XLEN'(1);
            end
            OPC_BRANCH: begin
                alu_c = rs1_val - rs2_val;
                if (br_taken_c) begin
                    next_pc_c = pc + imm_b;
                end
            end
            default: begin
                alu_c     = rs1_val + rs2_val;
                rf_we_c   = 1'b0;
                next_pc_c = pc_plus4;
            end
        endcase
    end

    // PC and register file state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            pc <= next_pc_c;
            if (rf_we_c && (rd != '0)) begin
                regs[rd] <= alu_c;
            end
        end
    end

    assign Addition_result = pc_plus4;
    assign RF_WRITING      = rf_we_c;
    assign Alu_Result      = alu_c;

endmodule

// File: tb/tb_data_path.sv
`timescale 1ns/1ps
// Scoreboard bench for data_path: an architectural RV32I model predicts each
// cycle's observable outputs; a negedge monitor compares them against the DUT.
module tb_data_path;

    logic        clk;
    logic        rst;
    logic [31:0] instruction_word;
    logic [31:0] Addition_result;
    logic        RF_WRITING;
    logic [31:0] Alu_Result;

    data_path #(.RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .instruction_word (instruction_word),
        .Addition_result  (Addition_result),
        .RF_WRITING       (RF_WRITING),
        .Alu_Result       (Alu_Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic        we;
        logic [31:0] add;
        logic [31:0] ins;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_regs [32];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", name, act, req);
        end
    endtask

    function automatic void model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    endfunction

    function automatic logic [31:0] shr_arith(input logic [31:0] a, input int sh);
        logic [31:0] fill;
        fill = (sh == 0) ? 32'h0 : ~(32'hFFFF_FFFF >> sh);
        return (a >> sh) | (a[31] ? fill : 32'h0);
    endfunction

    // Architectural meaning of the eight integer operations
    function automatic logic [31:0] arith(input logic [2:0] f3, input bit alt,
                                          input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? shr_arith(a, sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic bit branch_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Evaluate one instruction against the model state without changing it
    function automatic void exec(input logic [31:0] ins, output logic [31:0] res,
                                 output bit we, output logic [31:0] npc);
        logic [31:0] a, b, ii, iu, ib, ij;
        logic [2:0]  f3;
        a  = m_regs[ins[19:15]];
        b  = m_regs[ins[24:20]];
        f3 = ins[14:12];
        ii = $signed(ins) >>> 20;
        iu = ins & 32'hFFFF_F000;
        ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        res = a + b;
        we  = 1'b0;
        npc = m_pc + 32'd4;
        case (ins[6:0])
            7'h33: begin res = arith(f3, ins[30], a, b); we = 1'b1; end
            7'h13: begin res = arith(f3, (f3 == 3'd5) && ins[30], a, ii); we = 1'b1; end
            7'h37: begin res = iu; we = 1'b1; end
            7'h17: begin res = m_pc + iu; we = 1'b1; end
            7'h6F: begin res = m_pc + 32'd4; we = 1'b1; npc = m_pc + ij; end
            7'h67: begin res = m_pc + 32'd4; we = 1'b1; npc = (a + ii) & 32'hFFFF_FFFE; end
            7'h63: begin res = a - b; if (branch_taken(f3, a, b)) npc = m_pc + ib; end
            default: ;
        endcase
    endfunction

    // Apply one instruction for one cycle; the model commits only if the edge is out of reset
    task automatic step(input logic [31:0] ins);
        exp_t        e;
        logic [31:0] res, npc;
        bit          we;
        instruction_word = ins;
        exec(ins, res, we, npc);
        e.alu = res; e.we = we; e.add = m_pc + 32'd4; e.ins = ins;
        sb_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            if (we && ins[11:7] != 5'd0) m_regs[ins[11:7]] = res;
            m_pc = npc;
        end
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2, sh;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [6:0]  f7;
        logic [6:0]  nop_opc [5];
        logic [2:0]  br_f3 [6];
        nop_opc = '{7'h03, 7'h23, 7'h00, 7'h0F, 7'h73};
        br_f3   = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom_range(0, 7));
        sh  = 5'($urandom);
        imm = 12'($urandom);
        case ($urandom_range(0, 9))
            0, 1: begin
                f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                return {f7, rs2, rs1, f3, rd, 7'h33};
            end
            2, 3: begin
                if (f3 == 3'd1) imm = {7'h00, sh};
                if (f3 == 3'd5) imm = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, sh};
                return {imm, rs1, f3, rd, 7'h13};
            end
            4: return {20'($urandom), rd, 7'h37};
            5: return {20'($urandom), rd, 7'h17};
            6: return {20'($urandom), rd, 7'h6F};
            7: return {imm, rs1, 3'd0, rd, 7'h67};
            8: return {7'($urandom), rs2, rs1, br_f3[$urandom_range(0, 5)], 5'($urandom), 7'h63};
            default: return {25'($urandom), nop_opc[$urandom_range(0, 4)]};
        endcase
    endfunction

    // Monitor: every cycle with an outstanding expectation is compared at negedge
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check32($sformatf("alu[%08h]", e.ins), Alu_Result, e.alu);
            check32($sformatf("rf_we[%08h]", e.ins), 32'(RF_WRITING), 32'(e.we));
            check32($sformatf("pc4[%08h]", e.ins), Addition_result, e.add);
        end
    end

    initial begin
        rst = 1'b0;
        instruction_word = 32'h0;
        model_reset();
        @(posedge clk); #1;

        // Held in reset: PC stays at RESET_PC, outputs decode against zero regs
        step(32'h0000_0000);
        step(32'h00B5_0633);
        rst = 1'b1;
        repeat (3) step(32'h0000_0000);

        // Directed sequence: ADDI, R-type, x0 writes, branch, JAL
        step(32'h0080_0513);
        step(32'h0020_0593);
        step(32'h00B5_0633);
        step(32'h40B5_06B3);
        step(32'h00B5_1733);
        step(32'h0050_0013);
        step(32'h0000_0533);
        step(32'h0080_0513);
        step(32'h0080_0593);
        step(32'h00B5_0463);
        step(32'h0000_0000);
        step(32'h0080_00EF);
        step(32'h0000_0000);

        // Reset dropped between edges: effect is immediate, pending write is lost
        instruction_word = 32'h0020_0513;
        begin
            exp_t e;
            logic [31:0] res, npc;
            bit we;
            exec(instruction_word, res, we, npc);
            e.alu = res; e.we = we; e.add = m_pc + 32'd4; e.ins = instruction_word;
            sb_q.push_back(e);
        end
        @(negedge clk); #1;
        rst = 1'b0;
        model_reset();
        instruction_word = 32'h0005_0633;
        #1;
        check32("async_rst_pc4", Addition_result, 32'd4);
        check32("async_rst_x10", Alu_Result, 32'd0);
        @(posedge clk); #1;
        step(32'h0005_0633);
        rst = 1'b1;
        step(32'h0005_0633);

        // Randomized instruction stream
        for (int n = 0; n < 600; n++) begin
            step(rand_instr());
        end

        instruction_word = 32'h0;
        @(negedge clk); #1;
        check32("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
